// File: rtl/matmul_scheduler.sv
// Drives one shared inner_product unit through the N*N row/column pairs of C = A x B.
// It latches A and B on accept, collects each dot product into C, and hands the full C back.
module matmul_scheduler #(
    parameter int N      = 4,
    parameter int ELEM_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N*N*ELEM_W-1:0]    a_mat,
    input  logic [N*N*ELEM_W-1:0]    b_mat,
    input  logic                     mats_i_stb,
    output logic                     mats_i_ack,
    output logic [N*N*ELEM_W-1:0]    c_mat,
    output logic                     c_o_stb,
    input  logic                     c_o_ack,
    output logic                     busy,
    output logic [N*ELEM_W-1:0]      ip_row,
    output logic [N*ELEM_W-1:0]      ip_column,
    output logic                     ip_row_stb,
    input  logic                     ip_row_ack,
    output logic                     ip_column_stb,
    input  logic                     ip_column_ack,
    input  logic [ELEM_W-1:0]        ip_out,
    input  logic                     ip_out_stb,
    output logic                     ip_out_ack
);
    localparam int NN   = N * N;
    localparam int IDXW = (NN > 1) ? $clog2(NN) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                 state_q;
    logic [IDXW-1:0]        idx_q;
    logic [NN*ELEM_W-1:0]   a_q, b_q, c_q;
    logic [N*ELEM_W-1:0]    ip_row_q, ip_col_q;
    logic                   mats_ack_q, c_stb_q, busy_q;
    logic                   row_stb_q, col_stb_q, out_ack_q;

    logic [NN*ELEM_W-1:0]   src_a, src_b;
    logic [IDXW-1:0]        iss_idx;
    int                     iss_i, iss_j;
    logic [N*ELEM_W-1:0]    row_d, col_d;

    // Operands for the next issue: straight from the inputs on job accept (A/B are
    // being latched on that same edge), otherwise from the latched copies at idx+1.
    always_comb begin
        src_a   = (state_q == IDLE) ? a_mat : a_q;
        src_b   = (state_q == IDLE) ? b_mat : b_q;
        iss_idx = (state_q == IDLE) ? '0 : idx_q + IDXW'(1);
        iss_i   = int'(iss_idx) / N;
        iss_j   = int'(iss_idx) % N;
        row_d   = '0;
        col_d   = '0;
        for (int k = 0; k < N; k++) begin
            row_d[k*ELEM_W +: ELEM_W] = src_a[(iss_i*N + k)*ELEM_W +: ELEM_W];
            col_d[k*ELEM_W +: ELEM_W] = src_b[(k*N + iss_j)*ELEM_W +: ELEM_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            ip_row_q   <= '0;
            ip_col_q   <= '0;
            mats_ack_q <= 1'b0;
            c_stb_q    <= 1'b0;
            busy_q     <= 1'b0;
            row_stb_q  <= 1'b0;
            col_stb_q  <= 1'b0;
            out_ack_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mats_ack_q && mats_i_stb) begin
                        mats_ack_q <= 1'b0;
                        a_q        <= a_mat;
                        b_q        <= b_mat;
                        idx_q      <= '0;
                        busy_q     <= 1'b1;
                        ip_row_q   <= row_d;
                        ip_col_q   <= col_d;
                        row_stb_q  <= 1'b1;
                        col_stb_q  <= 1'b1;
                        state_q    <= ISSUE;
                    end else begin
                        mats_ack_q <= mats_i_stb && !mats_ack_q;
                    end
                end
                ISSUE: begin
                    // Row and column handshakes complete independently; data is held
                    // until both have gone.
                    if (ip_row_ack)
                        row_stb_q <= 1'b0;
                    if (ip_column_ack)
                        col_stb_q <= 1'b0;
                    if ((!row_stb_q || ip_row_ack) && (!col_stb_q || ip_column_ack)) begin
                        out_ack_q <= 1'b1;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (ip_out_stb && out_ack_q) begin
                        c_q[int'(idx_q)*ELEM_W +: ELEM_W] <= ip_out;
                        out_ack_q <= 1'b0;
                        if (idx_q == IDXW'(NN-1)) begin
                            c_stb_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q     <= idx_q + IDXW'(1);
                            ip_row_q  <= row_d;
                            ip_col_q  <= col_d;
                            row_stb_q <= 1'b1;
                            col_stb_q <= 1'b1;
                            state_q   <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (c_o_ack) begin
                        c_stb_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mats_i_ack    = mats_ack_q;
    assign c_mat         = c_q;
    assign c_o_stb       = c_stb_q;
    assign busy          = busy_q;
    assign ip_row        = ip_row_q;
    assign ip_column     = ip_col_q;
    assign ip_row_stb    = row_stb_q;
    assign ip_column_stb = col_stb_q;
    assign ip_out_ack    = out_ack_q;

endmodule

// File: tb/tb_matmul_scheduler.sv
// Scoreboarded bench: integer-valued float matrices, behavioural inner_product with
// programmable handshake delays, and a monitor checking order, stability and C.
module tb_matmul_scheduler;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int NN = N * N;
    localparam int N2 = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NN*W-1:0] a_mat, b_mat, c_mat;
    logic            mats_i_stb, mats_i_ack, c_o_stb, c_o_ack, busy;
    logic [N*W-1:0]  ip_row, ip_column;
    logic            ip_row_stb, ip_row_ack, ip_column_stb, ip_column_ack;
    logic [W-1:0]    ip_out;
    logic            ip_out_stb, ip_out_ack;

    matmul_scheduler #(.N(N), .ELEM_W(W)) dut (
        .clk(clk), .rst(rst), .a_mat(a_mat), .b_mat(b_mat),
        .mats_i_stb(mats_i_stb), .mats_i_ack(mats_i_ack),
        .c_mat(c_mat), .c_o_stb(c_o_stb), .c_o_ack(c_o_ack), .busy(busy),
        .ip_row(ip_row), .ip_column(ip_column),
        .ip_row_stb(ip_row_stb), .ip_row_ack(ip_row_ack),
        .ip_column_stb(ip_column_stb), .ip_column_ack(ip_column_ack),
        .ip_out(ip_out), .ip_out_stb(ip_out_stb), .ip_out_ack(ip_out_ack)
    );

    logic [N2*N2*W-1:0] a_mat2, b_mat2, c_mat2;
    logic               mats_i_stb2, mats_i_ack2, c_o_stb2, c_o_ack2, busy2;
    logic [N2*W-1:0]    ip_row2, ip_column2;
    logic               ip_row_stb2, ip_row_ack2, ip_column_stb2, ip_column_ack2;
    logic [W-1:0]       ip_out2;
    logic               ip_out_stb2, ip_out_ack2;

    matmul_scheduler #(.N(N2), .ELEM_W(W)) dut2 (
        .clk(clk), .rst(rst), .a_mat(a_mat2), .b_mat(b_mat2),
        .mats_i_stb(mats_i_stb2), .mats_i_ack(mats_i_ack2),
        .c_mat(c_mat2), .c_o_stb(c_o_stb2), .c_o_ack(c_o_ack2), .busy(busy2),
        .ip_row(ip_row2), .ip_column(ip_column2),
        .ip_row_stb(ip_row_stb2), .ip_row_ack(ip_row_ack2),
        .ip_column_stb(ip_column_stb2), .ip_column_ack(ip_column_ack2),
        .ip_out(ip_out2), .ip_out_stb(ip_out_stb2), .ip_out_ack(ip_out_ack2)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chkw(input string name, input logic [NN*W-1:0] act, input logic [NN*W-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chkv(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Float32 <-> integer helpers; stimulus uses small integers so products stay exact.
    function automatic int f2i(input logic [31:0] f);
        int e, v;
        logic [31:0] m;
        e = int'(f[30:23]);
        if (e == 0) return 0;
        m = {8'd0, 1'b1, f[22:0]};
        if (e >= 150) v = int'(m << (e - 150));
        else v = int'(m >> (150 - e));
        return f[31] ? -v : v;
    endfunction

    function automatic logic [31:0] i2f(input int v);
        logic [31:0] a, fr;
        int p;
        logic [7:0] e;
        if (v == 0) return 32'h0;
        a = (v < 0) ? 32'(-v) : 32'(v);
        p = 0;
        for (int b = 0; b < 31; b++) if (a[b]) p = b;
        e  = 8'(127 + p);
        fr = (p >= 23) ? (a >> (p - 23)) : (a << (23 - p));
        return {(v < 0), e, fr[22:0]};
    endfunction

    function automatic logic [31:0] dot(input logic [N*W-1:0] r, input logic [N*W-1:0] c);
        int s;
        s = 0;
        for (int k = 0; k < N; k++) s += f2i(r[k*W +: W]) * f2i(c[k*W +: W]);
        return i2f(s);
    endfunction

    function automatic logic [NN*W-1:0] pack(input int M[NN]);
        logic [NN*W-1:0] v;
        for (int i = 0; i < NN; i++) v[i*W +: W] = i2f(M[i]);
        return v;
    endfunction

    function automatic logic [NN*W-1:0] ref_c(input int A[NN], input int B[NN]);
        logic [NN*W-1:0] c;
        int s;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += A[i*N + k] * B[k*N + j];
                c[(i*N + j)*W +: W] = i2f(s);
            end
        return c;
    endfunction

    function automatic logic [N*W-1:0] exp_row(input logic [NN*W-1:0] m, input int n);
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = m[((n / N)*N + k)*W +: W];
        return v;
    endfunction

    function automatic logic [N*W-1:0] exp_col(input logic [NN*W-1:0] m, input int n);
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = m[(k*N + (n % N))*W +: W];
        return v;
    endfunction

    logic [NN*W-1:0] sb[$];
    int row_dly, col_dly, res_dly, c_dly;

    // Behavioural inner_product: acks after a programmable number of cycles, answers
    // res_dly cycles after it holds both operands.
    initial begin
        logic [N*W-1:0] row_cap, col_cap;
        bit have_row, have_col, row_x, col_x, out_x;
        int rcnt, ccnt, ocnt;
        ip_row_ack = 0; ip_column_ack = 0; ip_out_stb = 0; ip_out = '0;
        have_row = 0; have_col = 0; row_x = 0; col_x = 0; out_x = 0;
        rcnt = 0; ccnt = 0; ocnt = 0; row_cap = '0; col_cap = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ip_row_ack = 0; ip_column_ack = 0; ip_out_stb = 0; ip_out = '0;
                have_row = 0; have_col = 0; row_x = 0; col_x = 0; out_x = 0;
                rcnt = 0; ccnt = 0; ocnt = 0;
                continue;
            end
            if (out_x) begin ip_out_stb = 0; have_row = 0; have_col = 0; ocnt = 0; end
            if (row_x) have_row = 1;
            if (col_x) have_col = 1;
            if (ip_row_stb && !have_row) begin ip_row_ack = (rcnt >= row_dly); rcnt++; end
            else begin ip_row_ack = 0; rcnt = 0; end
            if (ip_column_stb && !have_col) begin ip_column_ack = (ccnt >= col_dly); ccnt++; end
            else begin ip_column_ack = 0; ccnt = 0; end
            row_x = ip_row_stb && ip_row_ack;
            col_x = ip_column_stb && ip_column_ack;
            if (row_x) row_cap = ip_row;
            if (col_x) col_cap = ip_column;
            if (have_row && have_col && !ip_out_stb) begin
                if (ocnt >= res_dly) begin ip_out_stb = 1; ip_out = dot(row_cap, col_cap); end
                ocnt++;
            end
            out_x = ip_out_stb && ip_out_ack;
        end
    end

    initial begin
        int cc;
        c_o_ack = 0;
        cc = 0;
        forever begin
            @(negedge clk);
            if (rst || !c_o_stb) begin c_o_ack = 0; cc = 0; end
            else begin c_o_ack = (cc >= c_dly); cc++; end
        end
    end

    // Monitor: everything is sampled mid-cycle, after the drivers have settled.
    int cyc = 0, n_row, n_col, n_wait, n_res, n_acc = 0, acc_cyc = 0, c_cyc = 0;
    logic [NN*W-1:0] cur_a, cur_b, p_cmat;
    logic [N*W-1:0]  p_row, p_col;
    bit p_row_x, p_col_x, p_out_x, p_mack, p_c_x, p_cstb, p_rstb, p_kstb, p_oack;

    initial begin
        n_row = 0; n_col = 0; n_wait = 0; n_res = 0;
        cur_a = '0; cur_b = '0; p_cmat = '0; p_row = '0; p_col = '0;
        {p_row_x, p_col_x, p_out_x, p_mack, p_c_x, p_cstb, p_rstb, p_kstb, p_oack} = '0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (rst) begin
                {p_row_x, p_col_x, p_out_x, p_mack, p_c_x, p_cstb, p_rstb, p_kstb, p_oack} = '0;
                continue;
            end
            if (p_row_x) chkv("row_stb_drop", ip_row_stb, 0);
            if (p_col_x) chkv("col_stb_drop", ip_column_stb, 0);
            if (p_out_x) chkv("out_ack_drop", ip_out_ack, 0);
            if (p_mack) chkv("mats_ack_pulse", mats_i_ack, 0);
            if (p_c_x) begin
                chkv("c_stb_after_ack", c_o_stb, 0);
                chkv("busy_after_ack", busy, 0);
            end
            if (p_cstb && !p_c_x) begin
                chkw("c_mat_held", c_mat, p_cmat);
                chkv("c_stb_held", c_o_stb, 1);
                chkv("busy_while_c", busy, 1);
            end
            if ((p_rstb || p_kstb) && (ip_row_stb || ip_column_stb)) begin
                chkw("ip_row_stable", ip_row, p_row);
                chkw("ip_col_stable", ip_column, p_col);
            end
            if (mats_i_ack) chkv("ack_only_idle", busy, 0);
            if (mats_i_stb && mats_i_ack) begin
                cur_a = a_mat; cur_b = b_mat;
                n_row = 0; n_col = 0; n_wait = 0; n_res = 0;
                n_acc++; acc_cyc = cyc;
            end
            if (ip_row_stb && ip_row_ack) begin
                chkw("row_order", ip_row, exp_row(cur_a, n_row));
                n_row++;
            end
            if (ip_column_stb && ip_column_ack) begin
                chkw("col_order", ip_column, exp_col(cur_b, n_col));
                n_col++;
            end
            if (ip_out_ack && !p_oack) n_wait++;
            if (ip_out_stb && ip_out_ack) n_res++;
            if (c_o_stb && c_o_ack) begin
                if (sb.size() == 0) chkv("c_unexpected", 1, 0);
                else chkw("c_mat", c_mat, sb.pop_front());
                chkv("row_xfers", n_row, NN);
                chkv("col_xfers", n_col, NN);
                chkv("wait_entries", n_wait, NN);
                c_cyc = cyc;
            end
            p_row_x = ip_row_stb && ip_row_ack;
            p_col_x = ip_column_stb && ip_column_ack;
            p_out_x = ip_out_stb && ip_out_ack;
            p_mack  = mats_i_ack;
            p_c_x   = c_o_stb && c_o_ack;
            p_cstb  = c_o_stb;
            p_rstb  = ip_row_stb;
            p_kstb  = ip_column_stb;
            p_oack  = ip_out_ack;
            p_cmat  = c_mat;
            p_row   = ip_row;
            p_col   = ip_column;
        end
    end

    // Small-instance inner_product: always ready, answers the cycle after both operands.
    int n2_iss = 0;
    initial begin
        logic [N*W-1:0] r2, k2;
        bit h2r, h2c, o2x;
        ip_row_ack2 = 0; ip_column_ack2 = 0; ip_out_stb2 = 0; ip_out2 = '0;
        r2 = '0; k2 = '0; h2r = 0; h2c = 0; o2x = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ip_row_ack2 = 0; ip_column_ack2 = 0; ip_out_stb2 = 0;
                h2r = 0; h2c = 0; o2x = 0;
                continue;
            end
            if (o2x) begin ip_out_stb2 = 0; h2r = 0; h2c = 0; end
            if (h2r && h2c && !ip_out_stb2) begin ip_out_stb2 = 1; ip_out2 = dot(r2, k2); end
            ip_row_ack2 = 1; ip_column_ack2 = 1;
            if (ip_row_stb2) begin r2 = '0; r2[N2*W-1:0] = ip_row2; h2r = 1; n2_iss++; end
            if (ip_column_stb2) begin k2 = '0; k2[N2*W-1:0] = ip_column2; h2c = 1; end
            o2x = ip_out_stb2 && ip_out_ack2;
        end
    end

    task automatic check_zero(input string tag);
        chkw({tag, "_c_mat"}, c_mat, '0);
        chkw({tag, "_ip_row"}, ip_row, '0);
        chkw({tag, "_ip_column"}, ip_column, '0);
        chkv({tag, "_outs"}, {mats_i_ack, c_o_stb, busy, ip_row_stb, ip_column_stb, ip_out_ack}, 0);
    endtask

    task automatic send_job(input int A[NN], input int B[NN]);
        bit ok;
        sb.push_back(ref_c(A, B));
        @(negedge clk);
        a_mat = pack(A); b_mat = pack(B); mats_i_stb = 1;
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk); #2;
            if (mats_i_ack) begin ok = 1; break; end
        end
        if (!ok) chkv("accept_timeout", 0, 1);
        @(negedge clk);
        mats_i_stb = 0;
    endtask

    task automatic wait_idle(input int bound, input string name);
        bit ok;
        ok = 0;
        for (int t = 0; t < bound; t++) begin
            @(negedge clk); #2;
            if (sb.size() == 0 && !busy && !c_o_stb) begin ok = 1; break; end
        end
        if (!ok) chkv({name, "_timeout"}, 0, 1);
    endtask

    task automatic rand_mat(output int M[NN]);
        for (int i = 0; i < NN; i++) M[i] = int'($urandom_range(0, 5)) - 2;
    endtask

    initial begin
        int A[NN], B[NN], I[NN], A2[NN], B2[NN];
        int a0;
        bit ok, sw;
        rst = 1; a_mat = '0; b_mat = '0; mats_i_stb = 0;
        a_mat2 = '0; b_mat2 = '0; mats_i_stb2 = 0; c_o_ack2 = 1;
        row_dly = 0; col_dly = 0; res_dly = 0; c_dly = 0;
        for (int i = 0; i < NN; i++) I[i] = (i / N == i % N) ? 1 : 0;
        #1;
        check_zero("reset");
        repeat (3) @(negedge clk);
        rst = 0;

        // identity x all-2.0
        for (int i = 0; i < NN; i++) B[i] = 2;
        res_dly = 2;
        send_job(I, B);
        wait_idle(2000, "t1");
        chkw("t1_c_const", c_mat, {NN{32'h40000000}});

        // skewed operand acks
        row_dly = 1; col_dly = 4;
        rand_mat(A); rand_mat(B);
        send_job(A, B);
        wait_idle(3000, "t2");

        // result backpressure
        row_dly = 0; col_dly = 0; res_dly = 0; c_dly = 20;
        rand_mat(A); rand_mat(B);
        send_job(A, B);
        wait_idle(3000, "t3");
        c_dly = 0;

        // reset after the fifth captured result
        res_dly = 1;
        rand_mat(A); rand_mat(B);
        send_job(A, B);
        ok = 0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk); #2;
            if (n_res >= 5) begin ok = 1; break; end
        end
        if (!ok) chkv("t4_res_timeout", 0, 1);
        @(posedge clk); #2;
        rst = 1;
        #1;
        check_zero("mid_rst");
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 0;
        send_job(I, I);
        wait_idle(2000, "t4");
        chkw("t4_c_ident", c_mat, pack(I));

        // mats_i_stb held through a job; second job follows closely
        rand_mat(A); rand_mat(B); rand_mat(A2); rand_mat(B2);
        sb.push_back(ref_c(A, B));
        sb.push_back(ref_c(A2, B2));
        a0 = n_acc; sw = 0; ok = 0;
        @(negedge clk);
        a_mat = pack(A); b_mat = pack(B); mats_i_stb = 1;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (n_acc == a0 + 1 && !sw) begin a_mat = pack(A2); b_mat = pack(B2); sw = 1; end
            #2;
            if (n_acc == a0 + 2) begin ok = 1; break; end
        end
        if (!ok) chkv("t5_timeout", 0, 1);
        @(negedge clk);
        mats_i_stb = 0;
        chkv("t5_accept_gap_ok", (acc_cyc - c_cyc) <= 2 && acc_cyc > c_cyc, 1);
        wait_idle(3000, "t5");

        // randomised handshake timing
        for (int j = 0; j < 6; j++) begin
            row_dly = int'($urandom_range(0, 3)); col_dly = int'($urandom_range(0, 3));
            res_dly = int'($urandom_range(0, 4)); c_dly = int'($urandom_range(0, 5));
            rand_mat(A); rand_mat(B);
            send_job(A, B);
            wait_idle(4000, "rand");
        end

        // N=2 instance: [[1,2],[3,4]] x identity
        n2_iss = 0;
        @(negedge clk);
        a_mat2 = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        b_mat2 = {32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000};
        mats_i_stb2 = 1;
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk); #2;
            if (mats_i_ack2) begin ok = 1; break; end
        end
        if (!ok) chkv("n2_accept_timeout", 0, 1);
        @(negedge clk);
        mats_i_stb2 = 0;
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk); #2;
            if (c_o_stb2) begin ok = 1; break; end
        end
        if (!ok) chkv("n2_result_timeout", 0, 1);
        chkw("n2_c", c_mat2, {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000});
        chkv("n2_issues", n2_iss, 4);

        chkv("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
